// File: rtl/corr_pkg.sv
// -----------------------------------------------------------------------------
// corr_pkg
// Shared definitions for the stream correlator: the correlation mode encoding
// and the width-generic bit-manipulation helpers used by the datapath.
// Helpers operate on CORR_MAX_W-wide vectors plus a run-time width argument so
// that any instance width up to CORR_MAX_W can share one definition; callers
// zero-extend their operands and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package corr_pkg;

   localparam int CORR_MAX_W = 64;

   typedef enum logic {
      CORR_DIRECT = 1'b0,
      CORR_FOLD   = 1'b1
   } corr_mode_e;

   // Interleave fold: odd window bits (descending) fill the upper half,
   // even window bits (ascending) fill the lower half, both read from the MSB.
   // Output bit o in the upper half takes w[2o-width+1]; in the lower half it
   // takes w[width-2-2o].
   function automatic logic [CORR_MAX_W-1:0] fold(input logic [CORR_MAX_W-1:0] w,
                                                  input int                    width);
      logic [CORR_MAX_W-1:0] f;
      logic [CORR_MAX_W-1:0] sh;
      int                    src;
      f   = '0;
      sh  = '0;
      src = 32'sd0;
      for (int o = 32'sd0; o < CORR_MAX_W; o++) begin
         if (o < width) begin
            if (o >= (width / 32'sd2)) begin
               src = (32'sd2 * o) - width + 32'sd1;
            end else begin
               src = width - 32'sd2 - (32'sd2 * o);
            end
            sh   = w >> src;
            f[o] = sh[0];
         end else begin
            f[o] = 1'b0;
         end
      end
      return f;
   endfunction

   // Rotate the low 'width' bits of p left by n (0 <= n < width).
   function automatic logic [CORR_MAX_W-1:0] rotl(input logic [CORR_MAX_W-1:0] p,
                                                  input int                    n,
                                                  input int                    width);
      logic [CORR_MAX_W-1:0] mask;
      logic [CORR_MAX_W-1:0] pm;
      mask = ~({CORR_MAX_W{1'b1}} << width);
      pm   = p & mask;
      return ((pm << n) | (pm >> (width - n))) & mask;
   endfunction

   // Number of zero bits among the low 'width' bits of x.
   function automatic int popcount_zeros(input logic [CORR_MAX_W-1:0] x,
                                         input int                    width);
      int cnt;
      cnt = 32'sd0;
      for (int i = 32'sd0; i < CORR_MAX_W; i++) begin
         if ((i < width) && (x[i] == 1'b0)) begin
            cnt = cnt + 32'sd1;
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/corr_score.sv
// -----------------------------------------------------------------------------
// corr_score
// Combinational scoring of one correlation word: counts the matching (zero)
// bits and compares the count against a threshold.
// Ports:
//   corr      in   WIDTH  correlation word (0 bit = pattern match)
//   threshold in   SW     minimum score for a match
//   score     out  SW     number of zero bits in corr
//   match     out  1      score >= threshold
// -----------------------------------------------------------------------------
module corr_score
   import corr_pkg::*;
#(
   parameter  int WIDTH = 10,
   localparam int SW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] corr,
   input  logic [SW-1:0]    threshold,
   output logic [SW-1:0]    score,
   output logic             match
);

   logic [SW-1:0] score_s;

   // Zero-count and threshold compare; threshold 0 always matches and any
   // threshold above WIDTH can never be reached.
   always_comb begin
      score_s = SW'(popcount_zeros(CORR_MAX_W'(corr), WIDTH));
      score   = score_s;
      match   = (score_s >= threshold);
   end

endmodule

// File: rtl/stream_correlator.sv
// -----------------------------------------------------------------------------
// stream_correlator
// Slides a WIDTH-bit window over a serial bit stream and correlates each full
// window against a programmable pattern. Two-stage valid/ready pipeline:
// S1 holds the correlation word and its threshold, S2 holds the registered
// result (correlation, score, match).
// Ports:
//   clk          in   1      rising-edge clock
//   reset_n      in   1      asynchronous active-low reset (clears pattern too)
//   flush        in   1      synchronous: empty window and pipeline
//   pattern_load in   1      capture pattern_in at this edge
//   pattern_in   in   WIDTH  new pattern
//   mode         in   1      0 = DIRECT, 1 = FOLD (sampled per accepted bit)
//   threshold    in   SW     match threshold (sampled per accepted bit)
//   in_valid     in   1      in_bit valid
//   in_bit       in   1      serial data bit
//   in_ready     out  1      bit accepted when in_valid && in_ready
//   out_valid    out  1      result valid
//   out_ready    in   1      downstream accepts result
//   correlation  out  WIDTH  correlation word
//   score        out  SW     number of matching bits
//   match        out  1      score >= threshold
//   window_full  out  1      WIDTH bits accepted since reset/flush
// -----------------------------------------------------------------------------
module stream_correlator
   import corr_pkg::*;
#(
   parameter  int WIDTH = 10,
   parameter  int ROT   = 3,
   localparam int SW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             pattern_load,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic             mode,
   input  logic [SW-1:0]    threshold,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] correlation,
   output logic [SW-1:0]    score,
   output logic             match,
   output logic             window_full
);

   localparam logic [SW-1:0] FULL_CNT = SW'(WIDTH);

   // State
   logic [WIDTH-1:0] pattern_r;
   logic [WIDTH-1:0] win_r;
   logic [SW-1:0]    cnt_r;
   logic             run_r;
   logic             window_full_r;
   logic             v1_r;
   logic [WIDTH-1:0] corr1_r;
   logic [SW-1:0]    thr1_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] correlation_r;
   logic [SW-1:0]    score_r;
   logic             match_r;

   // Combinational
   logic             adv1_s;
   logic             adv2_s;
   logic             accept_s;
   logic [WIDTH-1:0] win_next_s;
   logic [SW-1:0]    cnt_next_s;
   logic             full_next_s;
   logic [WIDTH-1:0] fold_win_s;
   logic [WIDTH-1:0] rot_pat_s;
   logic [WIDTH-1:0] corr_next_s;
   logic [SW-1:0]    score_s;
   logic             match_s;

   // Handshake: a stage may load when it is empty or its successor advances.
   // run_r keeps in_ready low while reset is asserted and until the first edge after.
   always_comb begin
      adv2_s   = ~out_valid_r | out_ready;
      adv1_s   = ~v1_r | adv2_s;
      in_ready = adv1_s & ~flush & run_r;
      accept_s = in_valid & in_ready;
   end

   // Next window / bit count as seen by the bit being accepted this cycle.
   always_comb begin
      if (accept_s) begin
         win_next_s = {win_r[WIDTH-2:0], in_bit};
         if (cnt_r != FULL_CNT) begin
            cnt_next_s = cnt_r + {{(SW-1){1'b0}}, 1'b1};
         end else begin
            cnt_next_s = cnt_r;
         end
      end else begin
         win_next_s = win_r;
         cnt_next_s = cnt_r;
      end
      full_next_s = (cnt_next_s == FULL_CNT);
   end

   // Correlation word for S1. pattern_r is the pre-load value when pattern_load
   // coincides with an accept, so that bit correlates against the old pattern.
   always_comb begin
      fold_win_s = WIDTH'(fold(CORR_MAX_W'(win_next_s), WIDTH));
      rot_pat_s  = WIDTH'(rotl(CORR_MAX_W'(pattern_r), ROT, WIDTH));
      case (corr_mode_e'(mode))
         CORR_DIRECT: corr_next_s = win_next_s ^ pattern_r;
         CORR_FOLD:   corr_next_s = fold_win_s ^ rot_pat_s;
         default:     corr_next_s = win_next_s ^ pattern_r;
      endcase
   end

   // Run enable: set at the first clock edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // Pattern register; flush deliberately leaves it untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern_r <= '0;
      end else if (pattern_load) begin
         pattern_r <= pattern_in;
      end
   end

   // Shift window, saturating bit count and window-full flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_r         <= '0;
         cnt_r         <= '0;
         window_full_r <= 1'b0;
      end else if (flush) begin
         win_r         <= '0;
         cnt_r         <= '0;
         window_full_r <= 1'b0;
      end else begin
         win_r         <= win_next_s;
         cnt_r         <= cnt_next_s;
         window_full_r <= full_next_s;
      end
   end

   // Stage 1: only bits that complete (or extend) a full window produce a result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_r    <= 1'b0;
         corr1_r <= '0;
         thr1_r  <= '0;
      end else if (flush) begin
         v1_r    <= 1'b0;
      end else if (adv1_s) begin
         v1_r <= accept_s & full_next_s;
         if (accept_s) begin
            corr1_r <= corr_next_s;
            thr1_r  <= threshold;
         end
      end
   end

   corr_score #(
      .WIDTH     (WIDTH)
   ) u_score (
      .corr      (corr1_r),
      .threshold (thr1_r),
      .score     (score_s),
      .match     (match_s)
   );

   // Stage 2: registered result, held stable while out_ready is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r   <= 1'b0;
         correlation_r <= '0;
         score_r       <= '0;
         match_r       <= 1'b0;
      end else if (flush) begin
         out_valid_r   <= 1'b0;
      end else if (adv2_s) begin
         out_valid_r <= v1_r;
         if (v1_r) begin
            correlation_r <= corr1_r;
            score_r       <= score_s;
            match_r       <= match_s;
         end
      end
   end

   assign out_valid   = out_valid_r;
   assign correlation = correlation_r;
   assign score       = score_r;
   assign match       = match_r;
   assign window_full = window_full_r;

endmodule
